// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one bit per cycle.
// Inputs above 10^DIGITS-1 saturate to all-nines and raise overflow.
module binary_to_bcd_seq #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX   = pow10(DIGITS) - 1;
    localparam int unsigned     BW    = 4 * DIGITS;
    localparam int unsigned     SW    = BW + WIDTH;
    localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q;
    logic [SW-1:0]      sr_q;
    logic [SW-1:0]      sr_d;
    logic [BW-1:0]      adj;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;
    logic               sat;
    logic [WIDTH-1:0]   load_val;

    // Saturate out-of-range inputs so every result digit stays within 0..9.
    always_comb begin
        sat      = 64'(bin_in) > MAX;
        load_val = sat ? WIDTH'(MAX) : bin_in;
    end

    // {scratch, binary} is one register: add-3 on scratch digits, then shift left by one.
    always_comb begin
        adj = sr_q[SW-1:WIDTH];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sr_q[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = sr_q[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        sr_d = {adj, sr_q[WIDTH-1:0]} << 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            sr_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q <= StShift;
                        sr_q    <= {{BW{1'b0}}, load_val};
                        count_q <= '0;
                        ovf_q   <= sat;
                        busy    <= 1'b1;
                    end
                end
                StShift: begin
                    sr_q    <= sr_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_q  <= StDone;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        bcd_out  <= sr_d[SW-1:WIDTH];
                        overflow <= ovf_q;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed and exhaustive checks of binary_to_bcd_seq at default parameters (WIDTH=10, DIGITS=3).
module tb_binary_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [9:0]  bin;
        logic [11:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t tbl[10];

    binary_to_bcd_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        int s;
        s = (v > 999) ? 999 : v;
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic digits_ok(input logic [11:0] b);
        for (int i = 0; i < 3; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Starts a conversion from IDLE and watches up to 20 cycles; cycle k is the k-th
    // negedge after the accepting edge. Optionally pulses start with another value mid-run.
    task automatic run_conv(input logic [9:0] v, input int pulse_at, input logic [9:0] pulse_val,
                            output logic [11:0] bcd, output logic ovf, output int lat,
                            output logic busy_ok);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start   = 1'b0;
        bin_in  = ~v;
        lat     = 0;
        busy_ok = 1'b1;
        bcd     = 'x;
        ovf     = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy !== (k <= 10)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                bcd = bcd_out;
                ovf = overflow;
                break;
            end
            if (pulse_at != 0 && k == pulse_at) begin
                start  = 1'b1;
                bin_in = pulse_val;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    initial begin
        logic [11:0] bcd;
        logic        ovf;
        logic        bok;
        int          lat;
        int          nd;
        int          t1;
        int          t2;
        logic [11:0] r1;
        logic [11:0] r2;

        tbl[0] = '{10'd0,    12'h000, 1'b0};
        tbl[1] = '{10'd59,   12'h059, 1'b0};
        tbl[2] = '{10'd999,  12'h999, 1'b0};
        tbl[3] = '{10'd1000, 12'h999, 1'b1};
        tbl[4] = '{10'd1023, 12'h999, 1'b1};
        tbl[5] = '{10'd7,    12'h007, 1'b0};
        tbl[6] = '{10'd1,    12'h001, 1'b0};
        tbl[7] = '{10'd512,  12'h512, 1'b0};
        tbl[8] = '{10'd100,  12'h100, 1'b0};
        tbl[9] = '{10'd909,  12'h909, 1'b0};

        reset  = 1'b1;
        start  = 1'b1;
        bin_in = 10'd345;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'h000);
        check("reset_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_conv(tbl[i].bin, 0, 10'd0, bcd, ovf, lat, bok);
            check($sformatf("tbl%0d_bcd", i), 32'(bcd), 32'(tbl[i].bcd));
            check($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd11);
            check($sformatf("tbl%0d_busy", i), 32'(bok), 32'd1);
        end

        // Results hold in IDLE after the done pulse.
        repeat (3) @(negedge clk);
        check("hold_bcd", 32'(bcd_out), 32'h909);
        check("hold_done", 32'(done), 32'd0);

        // start pulsed mid-conversion is ignored: one done, original value.
        run_conv(10'd123, 4, 10'd456, bcd, ovf, lat, bok);
        check("ignore_bcd", 32'(bcd), 32'h123);
        check("ignore_latency", 32'(lat), 32'd11);
        check("ignore_busy", 32'(bok), 32'd1);
        count_dones(15, nd);
        check("ignore_no_extra_done", 32'(nd), 32'd0);

        // start held high: back-to-back conversions one WIDTH+2 period apart.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd250;
        t1 = 0;
        t2 = 0;
        r1 = '0;
        r2 = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (t1 == 0) begin
                    t1     = k;
                    r1     = bcd_out;
                    bin_in = 10'd251;
                end else begin
                    t2    = k;
                    r2    = bcd_out;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_first_bcd", 32'(r1), 32'h250);
        check("held_second_bcd", 32'(r2), 32'h251);
        check("held_spacing", 32'(t2 - t1), 32'd12);
        @(negedge clk);

        // Leave overflow set so the reset clearing it is visible.
        run_conv(10'd1000, 0, 10'd0, bcd, ovf, lat, bok);
        check("pre_reset_ovf", 32'(ovf), 32'd1);

        // Reset in cycle 5 aborts the conversion without a done pulse.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd888;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'h000);
        check("abort_ovf", 32'(overflow), 32'd0);
        count_dones(15, nd);
        check("abort_no_done", 32'(nd), 32'd0);
        run_conv(10'd42, 0, 10'd0, bcd, ovf, lat, bok);
        check("after_reset_bcd", 32'(bcd), 32'h042);
        check("after_reset_latency", 32'(lat), 32'd11);

        // Exhaustive sweep against the decimal reference.
        for (int v = 0; v < 1024; v++) begin
            run_conv(10'(v), 0, 10'd0, bcd, ovf, lat, bok);
            check($sformatf("sweep%0d_bcd", v), 32'(bcd), 32'(ref_bcd(v)));
            check($sformatf("sweep%0d_ovf", v), 32'(ovf), 32'(v > 999));
            check($sformatf("sweep%0d_latency", v), 32'(lat), 32'd11);
            check($sformatf("sweep%0d_busy", v), 32'(bok), 32'd1);
            check($sformatf("sweep%0d_digits", v), 32'(digits_ok(bcd)), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
